// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU in the EX stage.
// Latency: WIDTH+1 cycles from start to the done pulse, 1 cycle for divide-by-zero/overflow.
// Backpressure: stall holds PC, IF/ID and ID/EX from the start cycle through the last RUN cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] dvd;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr;      // divisor magnitude
    logic             neg_q;
    logic             neg_r;

    // Operation classification and operand magnitudes at the start cycle
    logic             accept;
    logic             div_zero;
    logic             ovf;
    logic             special;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign accept   = (state == S_IDLE) && start && !flush;
    assign div_zero = (divisor == '0);
    assign ovf      = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign special  = div_zero || ovf;
    assign a_neg    = is_signed && dividend[WIDTH-1];
    assign b_neg    = is_signed && divisor[WIDTH-1];
    assign a_mag    = a_neg ? -dividend : dividend;
    assign b_mag    = b_neg ? -divisor : divisor;

    // One restoring step; the compare is WIDTH+1 bits so large divisors work
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic             last;

    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr};
    assign ge      = (shifted >= {1'b0, dsr});
    assign rem_nxt = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_nxt = {dvd[WIDTH-2:0], ge};
    assign last    = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush beats completion in RUN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = special ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pipeline stall: low in DONE so EX captures the result that cycle
    always_comb begin
        stall = 1'b0;
        if (accept || (state == S_RUN)) begin
            stall = 1'b1;
        end
    end

    // Registered status flags follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
        end
    end

    // Datapath: operand latch, iteration, and result load; results survive flush
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            if (div_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end else if (ovf) begin
                quotient  <= MIN_NEG;
                remainder <= '0;
            end else begin
                cnt   <= '0;
                rem   <= '0;
                dvd   <= a_mag;
                dsr   <= b_mag;
                neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r <= a_neg;
            end
        end else if ((state == S_RUN) && !flush) begin
            cnt <= cnt + CW'(1);
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            if (last) begin
                quotient  <= neg_q ? -dvd_nxt : dvd_nxt;
                remainder <= neg_r ? -rem_nxt : rem_nxt;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        stall;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    // RV32M division semantics computed with plain integer arithmetic
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output bit sp);
        longint sa;
        longint sb;
        sp = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            sp = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            r  = 32'd0;
            sp = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq;
        logic [31:0] er;
        bit          sp;
        int          lat;
        int          bcnt;
        int          sbad;
        ref_div(sgn, a, b, eq, er, sp);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        #1;
        chk(tag, "stall_start", stall, 1);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat  = 1;
        bcnt = 0;
        sbad = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (stall !== busy) sbad++;
            @(negedge clk);
            lat++;
        end
        chk(tag, "latency", lat, sp ? 1 : 33);
        chk(tag, "quotient", quotient, eq);
        chk(tag, "remainder", remainder, er);
        chk(tag, "busy_cycles", bcnt, sp ? 0 : 32);
        chk(tag, "stall_vs_busy", sbad, 0);
        chk(tag, "stall_in_done", stall, 0);
        @(negedge clk);
        chk(tag, "done_pulse", done, 0);
    endtask

    initial begin
        logic [31:0] pq;
        logic [31:0] pr;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          seen;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset", "busy", busy, 0);
        chk("reset", "done", done, 0);
        chk("reset", "quotient", quotient, 0);
        chk("reset", "remainder", remainder, 0);
        chk("reset", "stall", stall, 0);
        rst = 1'b0;

        // start together with flush must not launch anything
        @(negedge clk);
        start = 1'b1; dividend = 32'd10; divisor = 32'd3; flush = 1'b1;
        #1;
        chk("start_flush", "stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("start_flush", "busy", busy, 0);
        chk("start_flush", "done", done, 0);

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op("divu_by0", 1'b0, 32'h1234_5678, 32'd0);
        do_op("div_by0", 1'b1, 32'd5, 32'd0);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_big_dsr", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001);

        // Flush at RUN cycle 10: no done, previous results retained
        pq = 32'd0; pr = 32'h8000_0000;
        pq = (32'hFFFF_FFFF / 32'h8000_0001);
        pr = (32'hFFFF_FFFF % 32'h8000_0001);
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        repeat (9) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("flush", "busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush", "busy_after", busy, 0);
        chk("flush", "done_after", done, 0);
        chk("flush", "quotient_kept", quotient, pq);
        chk("flush", "remainder_kept", remainder, pr);
        chk("flush", "done_seen", seen, 0);
        do_op("after_flush_9_3", 1'b0, 32'd9, 32'd3);

        // Reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_run", "busy", busy, 0);
        chk("rst_run", "done", done, 0);
        chk("rst_run", "quotient", quotient, 0);
        chk("rst_run", "remainder", remainder, 0);
        chk("rst_run", "stall", stall, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("rst_run", "idle_after", seen, 0);

        // Random operands with a bias toward the corner cases
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: rb = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
